// File: rtl/seg_pkg.sv
// Shared seven-segment constants: the hex glyph encodings (active-high,
// bit 6 = a .. bit 0 = g), the all-off pattern and the segment bit indices.
package seg_pkg;

  localparam logic [6:0] SEG_0 = 7'h7E;
  localparam logic [6:0] SEG_1 = 7'h30;
  localparam logic [6:0] SEG_2 = 7'h6D;
  localparam logic [6:0] SEG_3 = 7'h79;
  localparam logic [6:0] SEG_4 = 7'h33;
  localparam logic [6:0] SEG_5 = 7'h5B;
  localparam logic [6:0] SEG_6 = 7'h5F;
  localparam logic [6:0] SEG_7 = 7'h70;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h7B;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h1F;
  localparam logic [6:0] SEG_C = 7'h4E;
  localparam logic [6:0] SEG_D = 7'h3D;
  localparam logic [6:0] SEG_E = 7'h4F;
  localparam logic [6:0] SEG_F = 7'h47;

  localparam logic [6:0] SEG_OFF = 7'h00;

  // Bit positions of the individual segments inside a 7-bit pattern
  localparam int SEG_IDX_A = 6;
  localparam int SEG_IDX_B = 5;
  localparam int SEG_IDX_C = 4;
  localparam int SEG_IDX_D = 3;
  localparam int SEG_IDX_E = 2;
  localparam int SEG_IDX_F = 1;
  localparam int SEG_IDX_G = 0;

endpackage

// File: rtl/hex_seg_decode.sv
// Combinational hex nibble to seven-segment decoder (active-high, abcdefg).
module hex_seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Map each nibble value to its glyph
  always_comb begin
    seg = SEG_OFF;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment scan driver. A shadow copy of the packed
// hex value, decimal points and blank mask is captured on load; one digit is
// lit per CLK_DIV-cycle slot, with the first BLANK_CYCLES of every slot dark
// to avoid ghosting. All outputs are registered; polarity is applied last.
// Optional feature macro: LEADING_ZERO_BLANK_EN (suppress leading zeros).
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int CLK_DIV        = 50000,
  parameter int BLANK_CYCLES   = 2,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic                    load,
  output logic [6:0]              seg,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   an
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(CLK_DIV);

  generate
    if (NUM_DIGITS < 1 || NUM_DIGITS > 8 || CLK_DIV < 2 ||
        BLANK_CYCLES < 0 || BLANK_CYCLES >= CLK_DIV) begin : g_bad_params
      $error("seg_scan_driver: illegal parameter combination");
    end
  endgenerate

  logic [4*NUM_DIGITS-1:0] shadow_value;
  logic [NUM_DIGITS-1:0]   shadow_dp;
  logic [NUM_DIGITS-1:0]   shadow_blank;
  logic [CNT_W-1:0]        div_cnt;
  logic [IDX_W-1:0]        dig_idx;

  logic [NUM_DIGITS-1:0]   suppress;
  logic [3:0]              sel_nibble;
  logic                    sel_dp;
  logic                    sel_blank;
  logic                    sel_suppress;
  logic [6:0]              dec_seg;

  logic [NUM_DIGITS-1:0]   an_p1;
  logic [6:0]              seg_p1;
  logic                    dp_p1;

  // Shadow capture of the display contents
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_value <= '0;
      shadow_dp    <= '0;
      shadow_blank <= '0;
    end else if (load) begin
      shadow_value <= value;
      shadow_dp    <= dp;
      shadow_blank <= blank;
    end
  end

  // Slot timer and digit index; the index advances on the last slot cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      dig_idx <= '0;
    end else if (div_cnt == CNT_W'(CLK_DIV - 1)) begin
      div_cnt <= '0;
      dig_idx <= (dig_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : dig_idx + 1'b1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Digit i (i>0) is a leading zero when it and every higher nibble are zero
  always_comb begin
    logic higher_zero;
    higher_zero = 1'b1;
    suppress    = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      higher_zero = higher_zero & (shadow_value[4*i +: 4] == 4'h0);
      suppress[i] = higher_zero;
    end
  end
`else
  assign suppress = '0;
`endif

  // Select the nibble and per-digit flags of the digit being scanned
  always_comb begin
    sel_nibble   = 4'h0;
    sel_dp       = 1'b0;
    sel_blank    = 1'b0;
    sel_suppress = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (dig_idx == IDX_W'(i)) begin
        sel_nibble   = shadow_value[4*i +: 4];
        sel_dp       = shadow_dp[i];
        sel_blank    = shadow_blank[i];
        sel_suppress = suppress[i];
      end
    end
  end

  hex_seg_decode u_decode (
    .nibble (sel_nibble),
    .seg    (dec_seg)
  );

  // ---- stage p1: registered outputs (active-high) ----
  // Dark during the anti-ghost window; forced blank keeps the anode on
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_p1  <= '0;
      seg_p1 <= SEG_OFF;
      dp_p1  <= 1'b0;
    end else if (div_cnt < CNT_W'(BLANK_CYCLES)) begin
      an_p1  <= '0;
      seg_p1 <= SEG_OFF;
      dp_p1  <= 1'b0;
    end else begin
      an_p1  <= NUM_DIGITS'(1) << dig_idx;
      seg_p1 <= (sel_blank || sel_suppress) ? SEG_OFF : dec_seg;
      dp_p1  <= sel_dp & ~sel_blank;
    end
  end

  assign seg    = (SEG_ACTIVE_LOW != 0) ? ~seg_p1 : seg_p1;
  assign dp_out = (SEG_ACTIVE_LOW != 0) ? ~dp_p1  : dp_p1;
  assign an     = (DIG_ACTIVE_LOW != 0) ? ~an_p1  : an_p1;

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
Time-multiplexed driver for NUM_DIGITS common-anode/cathode seven-segment digits. Holds a shadow copy of a packed hex value, scans one digit per slot and decodes each nibble to segments. Provides anti-ghost blanking at each slot start. Sits between the CPU output port / register file and the board display pins.

Parameters:
NUM_DIGITS, 4, digits scanned (1..8)
CLK_DIV, 50000, clk cycles per digit slot (>=2)
BLANK_CYCLES, 2, cycles at slot start with all anodes inactive (< CLK_DIV)
SEG_ACTIVE_LOW, 0, 1 = seg/dp_out driven inverted
DIG_ACTIVE_LOW, 1, 1 = an driven inverted

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
value  in  4*NUM_DIGITS  packed nibbles; digit i = value[4i+3:4i], digit 0 rightmost
dp  in  NUM_DIGITS  decimal-point request per digit
blank  in  NUM_DIGITS  1 = digit i forced dark
load  in  1  capture value/dp/blank into shadow registers
seg  out  7  segments, seg[6]=a .. seg[0]=g
dp_out  out  1  decimal point of active digit
an  out  NUM_DIGITS  one-hot digit enable

Behaviour:
- Reset (async, rst_n=0): shadow regs=0, div_cnt=0, dig_idx=0; an all inactive, seg all off, dp_out off (inactive/off = polarity-applied levels). Release takes effect on the next rising clk.
- load=1 at edge N: shadow updated at N; displayed from the output update at N+1. Input ports are ignored when load=0.
- div_cnt counts 0..CLK_DIV-1 and wraps.
- At div_cnt==CLK_DIV-1, dig_idx advances on the same edge, wrapping NUM_DIGITS-1 -> 0. With NUM_DIGITS=1, dig_idx stays at 0.
- All outputs are registered, computed from the current div_cnt and dig_idx; outputs lag those counters by one cycle.
- Blanking: while div_cnt < BLANK_CYCLES, an is all inactive and seg/dp_out are off.
- Otherwise an[dig_idx] is active and all other an bits are inactive.
- Otherwise seg = decode(shadow nibble[dig_idx]) and dp_out = shadow dp[dig_idx].
- If shadow blank[dig_idx]=1, seg and dp_out are off but an is still active (constant brightness).
- Decode, active-high before polarity, abcdefg:
  0=7E 1=30 2=6D 3=79 4=33 5=5B 6=5F 7=70 8=7F 9=7B A=77 b=1F C=4E d=3D E=4F F=47.
- Polarity inversion is the last step, applied to registered outputs only.
- load during a slot is not deferred: the change can appear mid-slot (next cycle).
- Illegal parameters (CLK_DIV<2, BLANK_CYCLES>=CLK_DIV, NUM_DIGITS outside 1..8): elaboration-time error.
- dig_idx width = max(1, clog2(NUM_DIGITS)); div_cnt width = clog2(CLK_DIV).

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: while scanning, a digit is dark (seg off, dp honoured) if its shadow nibble is 0 and all higher-index nibbles are 0. Digit 0 is never suppressed, so value 0 shows "0".
- The suppression mask is computed combinationally from the shadow registers.
- Undefined: no suppression; only the blank input darkens digits.

Decomposition:
- Shared package/include seg_pkg holds:
  - the 16 segment encodings as named constants (SEG_0..SEG_F)
  - SEG_OFF = 7'h00
  - segment bit-index constants SEG_A..SEG_G
- Sub-module hex_seg_decode: 4-bit nibble in, 7-bit active-high segments out, purely combinational. The top instantiates one copy after the nibble mux.

Test Plan:
Bench uses NUM_DIGITS=4, CLK_DIV=8, BLANK_CYCLES=2, SEG_ACTIVE_LOW=0, DIG_ACTIVE_LOW=1.
1. Reset, then load value=16'h1234, dp=0, blank=0 -> per 8-cycle slot:
   - first 2 cycles: an=4'b1111
   - then digit 0: an=4'b1110, seg=7'h33
   - following slots: 3 -> 7'h79 (an 1101), 2 -> 7'h6D (1011), 1 -> 7'h30 (0111)
   - then repeats.
2. Sweep value=16'hFEDC then 16'hBA98 -> every nibble matches the decode table, including b=1F and d=3D.
3. blank=4'b0100, dp=4'b0001 -> digit 2 slot: an=1011, seg=00; digit 0 slot: dp_out=1.
4. Assert rst_n=0 mid-slot on digit 2 -> an=4'b1111 and seg=00 immediately, without waiting for clk. After release: scan restarts at digit 0 with shadow=0, digit 0 shows 7'h7E.
5. load with value=16'h0000 then 16'hFFFF on consecutive edges -> second value appears one cycle after its load edge; no cycle shows a mixed nibble.
6. With LEADING_ZERO_BLANK_EN, value=16'h0050 -> digits 3 and 2 dark, digit 1 = 7'h5B, digit 0 = 7'h7E. value=0 -> only digit 0 lit (7'h7E).
